// File: rtl/udma_clkgen_pkg.sv
// Shared types and defaults for the uDMA clock-generator divider configuration initiator.
// The state encoding is exported so the top and any debug logic agree on it.
package udma_clkgen_pkg;

  localparam int unsigned DIV_W_DEFAULT       = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } cfg_state_e;

endpackage : udma_clkgen_pkg

// File: rtl/udma_cfg_ack_sync.sv
// Level synchroniser bringing the clock generator's acknowledge into the register domain.
// All stages clear to 0 so a freshly reset initiator never sees a phantom acknowledge.
module udma_cfg_ack_sync
  import udma_clkgen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic ack_i,
  output logic ack_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], ack_i};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ack_s_o = sync_q[SYNC_STAGES-1];

endmodule : udma_cfg_ack_sync

// File: rtl/udma_clkgen_cfg.sv
// Register-domain initiator of the four-phase divider handshake toward the peripheral clock generator.
// Writes landing during a transfer collapse into a single pending slot; the newest value is sent next.
module udma_clkgen_cfg
  import udma_clkgen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned DIV_W       = DIV_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic [DIV_W-1:0] clk_div_data_o,
  output logic             clk_div_valid_o,
  input  logic             clk_div_ack_i
);

  cfg_state_e       state_q, state_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [DIV_W-1:0] cur_q, cur_d;
  logic             done_q, done_d;

  logic             ack_s;
  logic             have_cfg;
  logic [DIV_W-1:0] load_div;

  udma_cfg_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .ack_i   (clk_div_ack_i),
    .ack_s_o (ack_s)
  );

  // A write in the same cycle as a slot consumption bypasses the slot, so it is never stale.
  assign have_cfg = pend_q | cfg_valid_i;
  assign load_div = cfg_valid_i ? cfg_div_i : pend_div_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cur_d      = cur_q;
    done_d     = 1'b0;

    if (cfg_valid_i) begin
      pend_d     = 1'b1;
      pend_div_d = cfg_div_i;
    end

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        // An acknowledge still high means the counterpart is finishing an old handshake.
        if (have_cfg && !ack_s) begin
          data_d  = load_div;
          valid_d = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        valid_d = 1'b1;
        if (ack_s) begin
          cur_d   = data_q;
          valid_d = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        valid_d = 1'b0;
        if (!ack_s) begin
          done_d = 1'b1;
          if (have_cfg) begin
            data_d  = load_div;
            valid_d = 1'b1;
            pend_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cur_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cur_q      <= cur_d;
      done_q     <= done_d;
    end
  end

  assign busy_o          = (state_q != ST_IDLE) | pend_q;
  assign done_o          = done_q;
  assign cur_div_o       = cur_q;
  assign clk_div_data_o  = data_q;
  assign clk_div_valid_o = valid_q;

endmodule : udma_clkgen_cfg

// File: tb/tb_udma_clkgen_cfg.sv
// Bench for udma_clkgen_cfg: directed handshake scenarios plus a randomized run against a
// behavioural clock-generator counterpart and a last-write-wins reference model.
module tb_udma_clkgen_cfg;

  localparam int SYNC = 3;
  localparam int DW   = 8;

  logic          clk;
  logic          rstn_i;
  logic [DW-1:0] cfg_div_i;
  logic          cfg_valid_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] cur_div_o;
  logic [DW-1:0] clk_div_data_o;
  logic          clk_div_valid_o;
  logic          clk_div_ack_i;

  udma_clkgen_cfg #(
    .SYNC_STAGES (SYNC),
    .DIV_W       (DW)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_valid_i     (cfg_valid_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .cur_div_o       (cur_div_o),
    .clk_div_data_o  (clk_div_data_o),
    .clk_div_valid_o (clk_div_valid_o),
    .clk_div_ack_i   (clk_div_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: newest accepted write, value expected on the wire, counterpart model.
  logic [DW-1:0] last_wr;
  logic [DW-1:0] exp_load;
  logic          cp_ack;
  logic          cp_force;
  logic          cp_fell;
  logic [DW-1:0] cp_data;
  int            cp_cnt;
  bit            rand_mode;
  int            done_cnt;
  int            hs_cnt;
  logic          busy_at_done;
  logic          valid_prev;
  logic [DW-1:0] data_prev;
  logic          ackh [SYNC+1];
  logic [DW-1:0] load_q [$];

  assign clk_div_ack_i = cp_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int next_delay();
    if (rand_mode) return int'($urandom_range(1, 20));
    return 5;
  endfunction

  // One clock: observe at the falling edge, then let the counterpart react.
  task automatic step();
    logic acks_before;
    @(negedge clk);
    cp_fell = 1'b0;
    for (int i = SYNC; i > 0; i--) ackh[i] = ackh[i-1];
    ackh[0] = cp_ack;
    if (!rstn_i) begin
      for (int i = 0; i <= SYNC; i++) ackh[i] = 1'b0;
      valid_prev = 1'b0;
      data_prev  = '0;
    end else begin
      if (cfg_valid_i) last_wr = cfg_div_i;
      acks_before = ackh[SYNC];
      if (clk_div_data_o != data_prev)
        chk("data_stable", {30'd0, valid_prev, acks_before}, 32'd0);
      if (clk_div_valid_o && !valid_prev) begin
        exp_load = last_wr;
        load_q.push_back(clk_div_data_o);
        chk("load_val", clk_div_data_o, last_wr);
      end
      if (done_o) begin
        done_cnt++;
        busy_at_done = busy_o;
        chk("cur_at_done", cur_div_o, cp_data);
        $display("handshake %0d done: cur_div=0x%0h busy=%0b", done_cnt, cur_div_o, busy_o);
      end
      valid_prev = clk_div_valid_o;
      data_prev  = clk_div_data_o;
    end
    if (cp_force) begin
      cp_ack = 1'b1;
    end else if (!cp_ack && clk_div_valid_o) begin
      if (cp_cnt <= 1) begin
        cp_ack  = 1'b1;
        cp_data = clk_div_data_o;
        chk("ack_data", clk_div_data_o, exp_load);
        cp_cnt  = next_delay();
      end else cp_cnt--;
    end else if (cp_ack && !clk_div_valid_o) begin
      if (cp_cnt <= 1) begin
        cp_ack  = 1'b0;
        cp_fell = 1'b1;
        hs_cnt++;
        cp_cnt  = next_delay();
      end else cp_cnt--;
    end
  endtask

  task automatic write(input logic [DW-1:0] v);
    cfg_valid_i = 1'b1;
    cfg_div_i   = v;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic run_idle(input int max, input string tag);
    int n = 0;
    while ((busy_o || clk_div_valid_o || cp_ack) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, (n < max), 1);
  endtask

  initial begin
    int d0, h0, l0, n, nw;
    rstn_i = 1'b0; cfg_valid_i = 1'b0; cfg_div_i = '0;
    cp_ack = 1'b0; cp_force = 1'b0; cp_fell = 1'b0; cp_data = '0;
    rand_mode = 1'b0; cp_cnt = 5; done_cnt = 0; hs_cnt = 0;
    last_wr = '0; exp_load = '0; busy_at_done = 1'b0;
    valid_prev = 1'b0; data_prev = '0;
    for (int i = 0; i <= SYNC; i++) ackh[i] = 1'b0;

    // Reset state
    repeat (3) step();
    rstn_i = 1'b1;
    step();
    chk("rst_valid", clk_div_valid_o, 0);
    chk("rst_data", clk_div_data_o, 0);
    chk("rst_cur", cur_div_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);

    // Single write, counterpart acks after 5 cycles
    d0 = done_cnt;
    write(8'h04);
    chk("t1_valid", clk_div_valid_o, 1);
    chk("t1_data", clk_div_data_o, 8'h04);
    chk("t1_busy", busy_o, 1);
    run_idle(200, "t1");
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_cur", cur_div_o, 8'h04);
    chk("t1_busy_at_done", busy_at_done, 0);

    // Three writes during one REQ coalesce to two handshakes
    d0 = done_cnt; h0 = hs_cnt; l0 = load_q.size();
    write(8'h02);
    write(8'h07);
    write(8'h09);
    chk("t2_frozen_valid", clk_div_valid_o, 1);
    chk("t2_frozen_data", clk_div_data_o, 8'h02);
    run_idle(300, "t2");
    chk("t2_hs_cnt", hs_cnt - h0, 2);
    chk("t2_done_cnt", done_cnt - d0, 2);
    chk("t2_cur", cur_div_o, 8'h09);
    chk("t2_loads", load_q.size() - l0, 2);
    if (load_q.size() - l0 == 2) begin
      chk("t2_load0", load_q[l0], 8'h02);
      chk("t2_load1", load_q[l0+1], 8'h09);
    end

    // Write landing exactly on the REL completion cycle
    write(8'h10);
    n = 0;
    while (!cp_fell && n < 200) begin
      step();
      n++;
    end
    chk("t3_fall_timeout", (n < 200), 1);
    repeat (SYNC) step();
    write(8'h11);
    chk("t3_done", done_o, 1);
    chk("t3_valid", clk_div_valid_o, 1);
    chk("t3_data", clk_div_data_o, 8'h11);
    run_idle(200, "t3");
    chk("t3_cur", cur_div_o, 8'h11);

    // Counterpart still acknowledging across our reset
    cp_force = 1'b1; cp_ack = 1'b1;
    rstn_i = 1'b0;
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (6) step();
    write(8'h03);
    chk("t4_valid_low", clk_div_valid_o, 0);
    chk("t4_busy", busy_o, 1);
    repeat (10) step();
    chk("t4_valid_wait", clk_div_valid_o, 0);
    chk("t4_busy_wait", busy_o, 1);
    cp_force = 1'b0; cp_ack = 1'b0; cp_cnt = next_delay();
    run_idle(200, "t4");
    chk("t4_cur", cur_div_o, 8'h03);

    // Reset in the middle of a request
    write(8'h05);
    step();
    chk("t5_req", clk_div_valid_o, 1);
    #1 rstn_i = 1'b0;
    #1;
    chk("t5_valid", clk_div_valid_o, 0);
    chk("t5_data", clk_div_data_o, 0);
    chk("t5_cur", cur_div_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_done", done_o, 0);
    d0 = done_cnt;
    cp_ack = 1'b0; cp_cnt = next_delay();
    repeat (2) step();
    rstn_i = 1'b1;
    step();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_busy_after", busy_o, 0);
    chk("t5_valid_after", clk_div_valid_o, 0);

    // Randomized writes and acknowledge delays
    rand_mode = 1'b1; cp_cnt = next_delay();
    d0 = done_cnt; h0 = hs_cnt; nw = 0;
    while (nw < 500) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid_i = 1'b1;
        cfg_div_i   = DW'($urandom_range(0, 255));
        nw++;
      end else begin
        cfg_valid_i = 1'b0;
      end
      step();
    end
    cfg_valid_i = 1'b0;
    run_idle(2000, "rnd");
    chk("rnd_cur", cur_div_o, last_wr);
    chk("rnd_cp_data", cp_data, last_wr);
    chk("rnd_done_vs_hs", done_cnt - d0, hs_cnt - h0);
    chk("rnd_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_udma_clkgen_cfg
